// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default width for the GCD controller
package gcd_pkg;
  localparam int GCD_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/gcd_sub_ctrl_sub.sv
// gcd_sub_ctrl_sub: shared WIDTH-bit subtractor, difference truncated with no borrow out
module gcd_sub_ctrl_sub
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff
);
  assign o_diff = i_a - i_b;
endmodule

// File: rtl/gcd_sub_ctrl.sv
// gcd_sub_ctrl: Euclid repeated-subtraction GCD sequencer around one shared subtractor
module gcd_sub_ctrl
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iter_cnt
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_ra, r_rb, w_in1, w_in2, w_diff;
  logic             w_a_gt, w_fin;
  assign w_a_gt = r_ra > r_rb;
  assign w_in1  = w_a_gt ? r_ra : r_rb;
  assign w_in2  = w_a_gt ? r_rb : r_ra;
  assign w_fin  = (r_ra == '0) || (r_rb == '0) || (r_ra == r_rb);
  assign busy   = r_state != IDLE;
  assign done   = r_state == DONE;
  gcd_sub_ctrl_sub #(.WIDTH(WIDTH)) u_sub (
    .i_a   (w_in1),
    .i_b   (w_in2),
    .o_diff(w_diff)
  );
  // DONE and the unused encoding both fall back to IDLE
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (start ? CALC : IDLE) :
             (r_state == CALC) ? (w_fin ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      gcd_out  <= '0;
      iter_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_ra     <= a_in;
        r_rb     <= b_in;
        iter_cnt <= '0;
      end else if (r_state == CALC) begin
        if (w_fin) begin
          gcd_out <= (r_ra == '0) ? r_rb : r_ra;
        end else begin
          if (w_a_gt) r_ra <= w_diff;
          else r_rb <= w_diff;
          iter_cnt <= iter_cnt + WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_gcd_sub_ctrl.sv
// tb_gcd_sub_ctrl: directed table vectors plus hand sequences for busy-start, reset and back-to-back
module tb_gcd_sub_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        busy, done;
  logic [15:0] gcd_out, iter_cnt;
  int          n_vec = 0;
  int          n_bad = 0;

  gcd_sub_ctrl #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .gcd_out (gcd_out),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic [15:0] it;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat follows the numbering where the cycle right after the start edge is T+1
  task automatic wait_done(input int already, output int lat);
    int n;
    n = already;
    while (!done && n < 70000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: done not seen after %0d cycles, expected within 70000", n);
    end
    lat = n + 1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    go(v.a, v.b);
    check($sformatf("busy_after_start(%0d,%0d)", v.a, v.b), int'(busy), 1);
    wait_done(0, lat);
    check($sformatf("latency(%0d,%0d)", v.a, v.b), lat, int'(v.it) + 2);
    check($sformatf("gcd(%0d,%0d)", v.a, v.b), int'(gcd_out), int'(v.g));
    check($sformatf("iter(%0d,%0d)", v.a, v.b), int'(iter_cnt), int'(v.it));
    @(posedge clk);
    #1;
    check($sformatf("done_pulse(%0d,%0d)", v.a, v.b), int'({done, busy}), 0);
  endtask

  initial begin
    int lat;
    logic [15:0] prev;
    vt[0] = '{16'd48, 16'd18, 16'd6, 16'd4};
    vt[1] = '{16'd0, 16'd0, 16'd0, 16'd0};
    vt[2] = '{16'd7, 16'd0, 16'd7, 16'd0};
    vt[3] = '{16'd0, 16'd9, 16'd9, 16'd0};
    vt[4] = '{16'd13, 16'd13, 16'd13, 16'd0};
    vt[5] = '{16'd100, 16'd75, 16'd25, 16'd3};
    vt[6] = '{16'd17, 16'd5, 16'd1, 16'd6};
    vt[7] = '{16'd8, 16'd12, 16'd4, 16'd2};
    vt[8] = '{16'd65535, 16'd1, 16'd1, 16'd65534};
    vt[9] = '{16'd21, 16'd14, 16'd7, 16'd2};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", int'({busy, done, gcd_out, iter_cnt}), 0);
    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // start while busy must be ignored
    go(16'd12, 16'd8);
    a_in  = 16'd100;
    b_in  = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1, lat);
    check("busy_start_latency", lat, 4);
    check("busy_start_gcd", int'(gcd_out), 4);
    check("busy_start_iter", int'(iter_cnt), 2);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("no_second_done", int'(done), 0);
    end

    // synchronous reset mid-calculation
    go(16'd1000, 16'd3);
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_done", int'(done), 0);
    check("mid_reset_gcd", int'(gcd_out), 0);
    check("mid_reset_iter", int'(iter_cnt), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", int'(busy), 0);
    run_vec(vt[9]);

    // back-to-back: start in the IDLE cycle right after done
    go(16'd48, 16'd18);
    wait_done(0, lat);
    prev = gcd_out;
    @(posedge clk);
    #1;
    check("b2b_idle", int'(busy), 0);
    a_in  = 16'd9;
    b_in  = 16'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accepted", int'(busy), 1);
    check("b2b_gcd_held", int'(gcd_out), int'(prev));
    wait_done(0, lat);
    check("b2b_latency", lat, 4);
    check("b2b_gcd", int'(gcd_out), 3);
    check("b2b_iter", int'(iter_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gcd_sub_ctrl.md
Name: gcd_sub_ctrl

Overview:
- Sequencing controller for the 16-bit GCD datapath.
- Computes GCD(a, b) by Euclid's repeated-subtraction algorithm, using a single shared subtractor: the larger operand minus the smaller, one subtraction per cycle.
- Owns the operand registers, the FSM, a start/done handshake and an iteration counter.
- Sits between the host logic that issues GCD requests and the subtractor instance.

Parameters:
WIDTH, 16, operand/result width; must match the subtractor width.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
a_in  input  WIDTH  operand A; captured on accepted start
b_in  input  WIDTH  operand B; captured on accepted start
busy  output  1  high in CALC and DONE states
done  output  1  one-cycle pulse; result valid
gcd_out  output  WIDTH  result; held until next accepted start or reset
iter_cnt  output  WIDTH  number of subtractions performed for the last/current request

Behaviour:
- Reset, taken at any clock edge including mid-CALC:
  - state=IDLE.
  - busy=0, done=0, gcd_out=0, iter_cnt=0.
  - Operand registers cleared; any in-flight computation is discarded.
- FSM states: IDLE, CALC, DONE. All outputs are registered or decoded from state; no combinational path from start to any output.
- IDLE:
  - If start=1: ra<=a_in, rb<=b_in, iter_cnt<=0, go CALC.
  - Otherwise hold; gcd_out and iter_cnt keep their previous values.
- CALC: each cycle evaluates termination first.
  - ra==0: gcd_out<=rb, go DONE. This covers gcd(0,0)=0.
  - rb==0: gcd_out<=ra, go DONE.
  - ra==rb: gcd_out<=ra, go DONE.
  - ra>rb: ra<=ra-rb, iter_cnt<=iter_cnt+1, stay in CALC.
  - ra<rb: rb<=rb-ra, iter_cnt<=iter_cnt+1, stay in CALC.
- Subtractor sharing: exactly one WIDTH-bit subtractor.
  - in1 = max(ra, rb), in2 = min(ra, rb), selected by a single unsigned compare.
  - The difference is written back only to the register that held the larger value.
  - No underflow is possible: in1 >= in2 always.
- DONE: done=1 for exactly this one cycle, gcd_out valid, go IDLE unconditionally.
- busy = (state != IDLE).
- start while busy (CALC or DONE) is ignored, not queued. Operands presented with it are discarded.
- Latency: start sampled at edge T; k = number of subtractions; done is high in cycle T+2+k.
  - Minimum latency is 2 (k=0).
  - Worst case: a=2^WIDTH-1, b=1 gives k=2^WIDTH-2, so iter_cnt never wraps.
- iter_cnt updates live during CALC and is final when done=1.
- Width rules: all compares unsigned; the subtraction is WIDTH bits, truncated, with no carry out used.

Decomposition:
- Package gcd_pkg holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2; encoding 2'd3 is illegal and recovers to IDLE.
  - default WIDTH=16.
- One sub-module: instantiate the existing SUB subtractor as the single shared datapath subtractor.
- Compare and operand muxes stay inline in gcd_sub_ctrl.

Test Plan:
- a=48, b=18, start pulse at T -> subtractions (30,18),(12,18),(12,6),(6,6); done at T+6; gcd_out=6; iter_cnt=4; busy high T+1..T+6.
- a=0, b=0 -> done at T+2, gcd_out=0, iter_cnt=0. a=7, b=0 -> gcd_out=7, done at T+2. a=0, b=9 -> gcd_out=9.
- a=65535, b=1 -> gcd_out=1, iter_cnt=65534, done at T+65536; no wrap and no underflow.
- a=12, b=8 started; start with a=100, b=10 pulsed at T+2 (busy) -> ignored; gcd_out=4, iter_cnt=2, done at T+4; no second done follows.
- a=1000, b=3 started; rst=1 at T+5 -> next cycle state IDLE, busy=0, done=0, gcd_out=0, iter_cnt=0. A fresh start with a=21, b=14 gives gcd_out=7, iter_cnt=2.
- Back-to-back: start in the cycle after done (IDLE), a=9, b=6 -> accepted; gcd_out=3, iter_cnt=2; the previous gcd_out holds until that start is accepted.
